// File: rtl/rc5_keyex_pkg.sv
// Shared RC5-32/12/16 constants and key-schedule helpers, common to key expansion and data path.
package rc5_keyex_pkg;

   localparam int unsigned W             = 32;
   localparam int unsigned KEY_W         = 128;
   localparam int unsigned RC5_NUM_S     = 26;
   localparam int unsigned RC5_NUM_L     = 4;
   localparam int unsigned RC5_MIX_ITERS = 78;
   localparam int unsigned TABLE_W       = W * RC5_NUM_S;

   localparam logic [W-1:0] P32 = 32'hB7E1_5163;
   localparam logic [W-1:0] Q32 = 32'h9E37_79B9;

   typedef logic [W-1:0] word_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MIX  = 1'b1
   } keyex_state_t;

   // Initial table entry: P32 + k*Q32 mod 2^32.
   function automatic word_t s_init(input int unsigned k);
      return word_t'(P32 + word_t'(k) * Q32);
   endfunction

   // Little-endian word w of the key, with key byte 0 in the key MSBs.
   function automatic word_t key_word(input logic [KEY_W-1:0] key, input int unsigned w);
      word_t r;
      for (int unsigned n = 0; n < 4; n++) begin
         r[8*n +: 8] = key[KEY_W - 1 - 8*(4*w + n) -: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/rc5_keyex_rol.sv
// Variable 32-bit rotate-left by a 5-bit amount.
module rc5_rol
   import rc5_keyex_pkg::*;
(
   input  logic [W-1:0] i_din,
   input  logic [4:0]   i_amt,
   output logic [W-1:0] o_dout_c
);

   logic [2*W-1:0] dbl_c;

   // The upper half of the doubled word shifted left is the rotation.
   always_comb begin
      dbl_c    = {i_din, i_din} << i_amt;
      o_dout_c = dbl_c[2*W-1:W];
   end

endmodule

// File: rtl/rc5_keyex.sv
// RC5-32/12/16 key expansion: one mixing iteration per clock, 78 iterations per key,
// expanded table S[0..25] packed with S[0] in the MSBs.
module rc5_keyex
   import rc5_keyex_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [KEY_W-1:0]   i_key,
   input  logic               i_key_en,
   output logic [TABLE_W-1:0] o_keyex,
   output logic               o_keyex_en,
   output logic               o_busy
);

   keyex_state_t state_q, state_d;
   logic         load_c, step_c, done_c;

   word_t        s_q [RC5_NUM_S];
   word_t        l_q [RC5_NUM_L];
   word_t        a_q, b_q;
   logic [4:0]   i_q;
   logic [1:0]   j_q;
   logic [6:0]   cnt_q;

   word_t        a_sum_c, a_new_c, ab_c, b_sum_c, b_new_c;

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Strobes are only accepted in IDLE, so a run in progress cannot be disturbed.
   always_comb begin
      state_d = state_q;
      load_c  = 1'b0;
      step_c  = 1'b0;
      done_c  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_key_en) begin
               load_c  = 1'b1;
               state_d = ST_MIX;
            end
         end
         ST_MIX: begin
            step_c = 1'b1;
            if (cnt_q == 7'(RC5_MIX_ITERS - 1)) begin
               done_c  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // One mixing step; the fixed rotate-by-3 is wiring, the data-dependent one uses the rotator.
   assign a_sum_c = s_q[i_q] + a_q + b_q;
   assign a_new_c = {a_sum_c[W-4:0], a_sum_c[W-1:W-3]};
   assign ab_c    = a_new_c + b_q;
   assign b_sum_c = l_q[j_q] + ab_c;

   rc5_rol u_rol (
      .i_din    (b_sum_c),
      .i_amt    (ab_c[4:0]),
      .o_dout_c (b_new_c)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned k = 0; k < RC5_NUM_S; k++) s_q[k] <= '0;
         for (int unsigned k = 0; k < RC5_NUM_L; k++) l_q[k] <= '0;
         a_q        <= '0;
         b_q        <= '0;
         i_q        <= '0;
         j_q        <= '0;
         cnt_q      <= '0;
         o_keyex_en <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         o_keyex_en <= done_c;
         o_busy     <= (state_d == ST_MIX);
         if (load_c) begin
            for (int unsigned k = 0; k < RC5_NUM_S; k++) s_q[k] <= s_init(k);
            for (int unsigned k = 0; k < RC5_NUM_L; k++) l_q[k] <= key_word(i_key, k);
            a_q   <= '0;
            b_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            cnt_q <= '0;
         end else if (step_c) begin
            s_q[i_q] <= a_new_c;
            l_q[j_q] <= b_new_c;
            a_q      <= a_new_c;
            b_q      <= b_new_c;
            i_q      <= (i_q == 5'(RC5_NUM_S - 1)) ? 5'd0 : i_q + 5'd1;
            j_q      <= j_q + 2'd1;
            cnt_q    <= cnt_q + 7'd1;
         end
      end
   end

   always_comb begin
      o_keyex = '0;
      for (int unsigned k = 0; k < RC5_NUM_S; k++) begin
         o_keyex[W*(RC5_NUM_S - 1 - k) +: W] = s_q[k];
      end
   end

endmodule

// File: tb/tb_rc5_keyex.sv
// Self-checking bench for rc5_keyex: scoreboard of model tables, latency, strobe filtering,
// reset behaviour and an end-to-end RC5 encrypt/decrypt of the zero-key table.
module tb_rc5_keyex;

   logic         i_clk;
   logic         i_rst;
   logic [127:0] i_key;
   logic         i_key_en;
   logic [831:0] o_keyex;
   logic         o_keyex_en;
   logic         o_busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [831:0] sb [$];

   rc5_keyex dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_key      (i_key),
      .i_key_en   (i_key_en),
      .o_keyex    (o_keyex),
      .o_keyex_en (o_keyex_en),
      .o_busy     (o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] r);
      return (x << r) | (x >> (32 - int'(r)));
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] r);
      return (x >> r) | (x << (32 - int'(r)));
   endfunction

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Software key schedule, written independently in the textbook form.
   function automatic logic [831:0] model_table(input logic [127:0] key);
      logic [31:0]  s [26];
      logic [31:0]  l [4];
      logic [31:0]  a, b, t;
      logic [7:0]   kb;
      logic [831:0] tab;
      int ii, jj;
      for (int n = 0; n < 16; n++) begin
         kb = key[127 - 8*n -: 8];
         l[n/4][8*(n%4) +: 8] = kb;
      end
      s[0] = 32'hB7E15163;
      for (int k = 1; k < 26; k++) s[k] = s[k-1] + 32'h9E3779B9;
      a = 0; b = 0; ii = 0; jj = 0;
      for (int it = 0; it < 78; it++) begin
         a = rotl(s[ii] + a + b, 5'd3);
         s[ii] = a;
         t = a + b;
         b = rotl(l[jj] + t, t[4:0]);
         l[jj] = b;
         ii = (ii + 1) % 26;
         jj = (jj + 1) % 4;
      end
      for (int k = 0; k < 26; k++) tab[32*(25-k) +: 32] = s[k];
      return tab;
   endfunction

   function automatic logic [63:0] rc5_enc(input logic [831:0] tab, input logic [63:0] pt);
      logic [31:0] s [26];
      logic [31:0] a, b;
      for (int k = 0; k < 26; k++) s[k] = tab[32*(25-k) +: 32];
      a = pt[63:32] + s[0];
      b = pt[31:0] + s[1];
      for (int r = 1; r <= 12; r++) begin
         a = rotl(a ^ b, b[4:0]) + s[2*r];
         b = rotl(b ^ a, a[4:0]) + s[2*r+1];
      end
      return {a, b};
   endfunction

   function automatic logic [63:0] rc5_dec(input logic [831:0] tab, input logic [63:0] ct);
      logic [31:0] s [26];
      logic [31:0] a, b;
      for (int k = 0; k < 26; k++) s[k] = tab[32*(25-k) +: 32];
      a = ct[63:32];
      b = ct[31:0];
      for (int r = 12; r >= 1; r--) begin
         b = rotr(b - s[2*r+1], a[4:0]) ^ a;
         a = rotr(a - s[2*r], b[4:0]) ^ b;
      end
      return {a - s[0], b - s[1]};
   endfunction

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_tab(input string tag, input logic [831:0] obs, input logic [831:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [127:0] key);
      i_key    = key;
      i_key_en = 1'b1;
      tick();
      i_key_en = 1'b0;
      sb.push_back(model_table(key));
      chk("busy_after_accept", 64'(o_busy), 64'd1);
   endtask

   // Runs until the done pulse (bounded), optionally strobing another key on chosen edges.
   task automatic wait_done(input int sa, input int sbk, input int sc,
                            input logic [127:0] other, output int lat);
      lat = -1;
      for (int c = 1; c <= 200; c++) begin
         if (c == sa || c == sbk || c == sc) begin
            i_key    = other;
            i_key_en = 1'b1;
         end
         tick();
         i_key_en = 1'b0;
         if (o_keyex_en === 1'b1) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic check_done(input string tag, input int lat);
      logic [831:0] exp;
      chk({tag, "_latency"}, 64'(lat), 64'd78);
      chk({tag, "_busy_low"}, 64'(o_busy), 64'd0);
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s_scoreboard: observed empty queue expected one entry", tag);
      end else begin
         exp = sb.pop_front();
         chk_tab({tag, "_table"}, o_keyex, exp);
      end
   endtask

   task automatic watch(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         tick();
         if (o_keyex_en === 1'b1) pulses++;
      end
   endtask

   initial begin
      int           lat, pulses;
      logic [63:0]  ct, pt;
      logic [831:0] held;
      logic [127:0] rkey;

      i_rst    = 1'b1;
      i_key_en = 1'b0;
      i_key    = '1;

      // Reset held with strobes toggling.
      for (int c = 0; c < 3; c++) begin
         i_key_en = (c % 2 == 0);
         tick();
         chk("reset_keyex", 64'(o_keyex == '0), 64'd1);
         chk("reset_en", 64'(o_keyex_en), 64'd0);
         chk("reset_busy", 64'(o_busy), 64'd0);
      end
      i_key_en = 1'b0;
      i_rst    = 1'b0;
      tick();

      // Zero key against the model and the known RC5 vector.
      start(128'h0);
      wait_done(-1, -1, -1, 128'h0, lat);
      check_done("zero_key", lat);
      held = o_keyex;
      ct = rc5_enc(o_keyex, 64'h0);
      chk("zero_key_encrypt", {bswap(ct[63:32]), bswap(ct[31:0])}, 64'h21A5DBEE154B8F6D);
      pt = rc5_dec(o_keyex, ct);
      chk("zero_key_decrypt", pt, 64'h0);
      watch(5, pulses);
      chk("hold_no_pulse", 64'(pulses), 64'd0);
      chk_tab("hold_table", o_keyex, held);

      // Byte order.
      start(128'h000102030405060708090A0B0C0D0E0F);
      wait_done(-1, -1, -1, 128'h0, lat);
      check_done("byte_order", lat);

      // Strobes during busy, including the final iteration edge, are ignored.
      start(128'h0123456789ABCDEF_FEDCBA9876543210);
      wait_done(1, 40, 78, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, lat);
      check_done("busy_strobes", lat);
      watch(100, pulses);
      chk("busy_strobes_single_pulse", 64'(pulses), 64'd0);
      chk("busy_strobes_idle", 64'(o_busy), 64'd0);

      // Strobe on the pulse cycle starts a fresh run.
      start(128'h11111111_22222222_33333333_44444444);
      wait_done(-1, -1, -1, 128'h0, lat);
      check_done("pre_b2b", lat);
      start(128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
      wait_done(-1, -1, -1, 128'h0, lat);
      check_done("b2b", lat);

      // Reset mid-run aborts without a pulse.
      start(128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
      repeat (29) tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      if (sb.size() != 0) void'(sb.pop_front());
      chk("abort_keyex", 64'(o_keyex == '0), 64'd1);
      chk("abort_busy", 64'(o_busy), 64'd0);
      chk("abort_en", 64'(o_keyex_en), 64'd0);
      watch(90, pulses);
      chk("abort_no_pulse", 64'(pulses), 64'd0);
      start(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
      wait_done(-1, -1, -1, 128'h0, lat);
      check_done("after_abort", lat);

      // One pseudo-random key.
      rkey = {$urandom, $urandom, $urandom, $urandom};
      start(rkey);
      wait_done(-1, -1, -1, 128'h0, lat);
      check_done("random_key", lat);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
